// File: rtl/ysyx_24080014_lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states,
// byte-mask and sign/zero-extension helpers.
package ysyx_24080014_lsu_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   // Byte-enable pattern of an access before it is shifted into its lane.
   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         SZ_BYTE: m = 8'h01;
         SZ_HALF: m = 8'h03;
         SZ_WORD: m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   function automatic logic [2:0] low_mask(input logic [1:0] size);
      logic [2:0] m;
      case (size)
         SZ_BYTE: m = 3'b000;
         SZ_HALF: m = 3'b001;
         SZ_WORD: m = 3'b011;
         default: m = 3'b111;
      endcase
      return m;
   endfunction

   function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] size);
      return |(lo & low_mask(size));
   endfunction

   function automatic logic [2:0] align_lo(input logic [2:0] lo, input logic [1:0] size);
      return lo & ~low_mask(size);
   endfunction

   function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] size,
                                          input logic uns);
      logic [63:0] r;
      case (size)
         SZ_BYTE: r = uns ? {56'h0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
         SZ_HALF: r = uns ? {48'h0, d[15:0]} : {{48{d[15]}}, d[15:0]};
         SZ_WORD: r = uns ? {32'h0, d[31:0]} : {{32{d[31]}}, d[31:0]};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ysyx_24080014_lsu_align.sv
// Lane steering for the LSU: store byte-enable/data shift and load
// extraction with sign/zero extension. Purely combinational.
module ysyx_24080014_lsu_align
   import ysyx_24080014_lsu_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int NB     = DATA_W / 8,
   localparam int OFF_W  = $clog2(NB)
) (
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [OFF_W-1:0]  off,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rsp_rdata,
   output logic [NB-1:0]     wmask,
   output logic [DATA_W-1:0] wdata_sh,
   output logic [DATA_W-1:0] rdata_ext
);

   logic [DATA_W-1:0] rsp_sh;

   assign wmask     = NB'({8'h00, size_mask(size)} << off);
   assign wdata_sh  = wdata << {off, 3'b000};
   assign rsp_sh    = rsp_rdata >> {off, 3'b000};
   assign rdata_ext = DATA_W'(extend(64'(rsp_sh), size, uns));

endmodule

// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: one outstanding access, IDLE->REQ->WAIT->RESP with a WAIT
// timeout. Define YSYX_24080014_LSU_MISALIGN_EN to reject misaligned accesses.
module ysyx_24080014_lsu
   import ysyx_24080014_lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_wen,
   input  logic [1:0]          in_size,
   input  logic                in_unsigned,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [DATA_W-1:0]   in_wdata,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_rdata,
   output logic                out_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_wen,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_rdata
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   lsu_state_e        state_q, state_d;
   logic              wen_q, wen_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [1:0]        size_eff;
   logic [ADDR_W-1:0] addr_cap;
   logic              bad_access;
   logic [DATA_W-1:0] ld_data;

   // Request qualification. A dword on a 32-bit bus has no legal lane layout.
`ifdef YSYX_24080014_LSU_MISALIGN_EN
   always_comb begin
      size_eff   = in_size;
      addr_cap   = in_addr;
      bad_access = misaligned(in_addr[2:0], in_size) || (DATA_W == 32 && in_size == SZ_DWORD);
   end
`else
   // Without rejection, an oversized access on a 32-bit bus degrades to a word
   // and every address is aligned down to its access size.
   always_comb begin
      size_eff   = (DATA_W == 32 && in_size == SZ_DWORD) ? SZ_WORD : in_size;
      addr_cap   = {in_addr[ADDR_W-1:3], align_lo(in_addr[2:0], size_eff)};
      bad_access = 1'b0;
   end
`endif

   ysyx_24080014_lsu_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .size      (size_q),
      .uns       (uns_q),
      .off       (addr_q[OFF_W-1:0]),
      .wdata     (wdata_q),
      .rsp_rdata (mem_rsp_rdata),
      .wmask     (mem_wmask),
      .wdata_sh  (mem_wdata),
      .rdata_ext (ld_data)
   );

   always_comb begin
      state_d = state_q;
      wen_d   = wen_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               wen_d   = in_wen;
               size_d  = size_eff;
               uns_d   = in_unsigned;
               addr_d  = addr_cap;
               wdata_d = in_wdata;
               if (bad_access) begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            if (mem_rsp_valid) begin
               state_d = ST_RESP;
               err_d   = 1'b0;
               rdata_d = wen_q ? '0 : ld_data;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = ST_RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (out_ready) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wen_q   <= 1'b0;
         size_q  <= SZ_BYTE;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready      = (state_q == ST_IDLE);
   assign mem_req_valid = (state_q == ST_REQ);
   assign out_valid     = (state_q == ST_RESP);
   assign out_rdata     = rdata_q;
   assign out_err       = err_q;
   assign mem_wen       = wen_q;
   assign mem_addr      = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Directed bench for the LSU with DATA_W=32 and TIMEOUT=4; the misaligned
// scenario follows YSYX_24080014_LSU_MISALIGN_EN when it is defined.
module tb_ysyx_24080014_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_wen, in_unsigned;
   logic [1:0]  in_size;
   logic [31:0] in_addr, in_wdata;
   logic        out_valid, out_ready, out_err;
   logic [31:0] out_rdata;
   logic        mem_req_valid, mem_req_ready, mem_wen;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ysyx_24080014_lsu #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_wen        (in_wen),
      .in_size       (in_size),
      .in_unsigned   (in_unsigned),
      .in_addr       (in_addr),
      .in_wdata      (in_wdata),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_rdata     (out_rdata),
      .out_err       (out_err),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_wen       (mem_wen),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wmask     (mem_wmask),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single cycle (DUT must be in IDLE).
   task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      in_valid    = 1'b1;
      in_wen      = wen;
      in_size     = size;
      in_unsigned = uns;
      in_addr     = addr;
      in_wdata    = wdata;
      tick();
      in_valid    = 1'b0;
   endtask

   task automatic respond(input logic [31:0] data);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = data;
      tick();
      mem_rsp_valid = 1'b0;
   endtask

   task automatic finish_resp();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_vec++;
      if ({in_ready, out_valid, mem_req_valid, out_err} !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_flags got %b exp 1000", {in_ready, out_valid, mem_req_valid, out_err});
      end
      n_vec++;
      if (out_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_rdata got %h exp 00000000", out_rdata);
      end
      $display("txn reset done");
   endtask

   task automatic test_load_byte();
      mem_req_ready = 1'b1;
      issue(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0);
      n_vec++;
      if ({mem_req_valid, mem_wen, in_ready, mem_addr} !== {3'b100, 32'h8000_0000}) begin
         n_err++;
         $display("FAIL lb_req got v/wen/rdy=%b%b%b addr=%h exp 100 80000000",
                  mem_req_valid, mem_wen, in_ready, mem_addr);
      end
      tick();
      respond(32'h80FF_FFFF);
      n_vec++;
      if ({out_valid, out_err, out_rdata} !== {2'b10, 32'hFFFF_FF80}) begin
         n_err++;
         $display("FAIL lb_resp got v=%b err=%b rdata=%h exp v=1 err=0 ffffff80",
                  out_valid, out_err, out_rdata);
      end
      finish_resp();
      n_vec++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL lb_release got rdy/v=%b%b exp 10", in_ready, out_valid);
      end
      $display("txn load byte @80000003 rdata=%h", 32'hFFFF_FF80);
   endtask

   task automatic test_load_variants();
      logic [1:0]  sz[6]  = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 2'd1};
      logic        un[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] ad[6]  = '{32'h8000_0002, 32'h8000_0002, 32'h8000_0004,
                              32'h8000_0001, 32'h8000_0001, 32'h8000_0003};
      logic [31:0] rsp[6] = '{32'h8001_1234, 32'h8001_1234, 32'hDEAD_BEEF,
                              32'h1234_5678, 32'hCAFE_F00D, 32'hABCD_0000};
      logic [31:0] ea[6]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004,
                              32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] er[6]  = '{32'h0000_8001, 32'hFFFF_8001, 32'hDEAD_BEEF,
                              32'h0000_0056, 32'hCAFE_F00D, 32'hFFFF_ABCD};
      int n;
`ifdef YSYX_24080014_LSU_MISALIGN_EN
      n = 4;
`else
      n = 6;
`endif
      for (int i = 0; i < n; i++) begin
         issue(1'b0, sz[i], un[i], ad[i], 32'h0);
         n_vec++;
         if ({mem_req_valid, mem_addr} !== {1'b1, ea[i]}) begin
            n_err++;
            $display("FAIL ld%0d_addr got v=%b addr=%h exp v=1 %h", i, mem_req_valid, mem_addr, ea[i]);
         end
         tick();
         respond(rsp[i]);
         n_vec++;
         if ({out_valid, out_err, out_rdata} !== {2'b10, er[i]}) begin
            n_err++;
            $display("FAIL ld%0d_data got v=%b err=%b rdata=%h exp v=1 err=0 %h",
                     i, out_valid, out_err, out_rdata, er[i]);
         end
         finish_resp();
         $display("txn load size=%0d addr=%h rdata=%h", sz[i], ad[i], er[i]);
      end
   endtask

   task automatic test_store();
      logic [1:0]  sz[3] = '{2'd1, 2'd0, 2'd2};
      logic [31:0] ad[3] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0008};
      logic [31:0] wd[3] = '{32'h0000_BEEF, 32'h0000_00A5, 32'h1234_5678};
      logic [31:0] ea[3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0008};
      logic [31:0] ed[3] = '{32'hBEEF_0000, 32'h0000_A500, 32'h1234_5678};
      logic [3:0]  em[3] = '{4'hC, 4'h2, 4'hF};
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, sz[i], 1'b0, ad[i], wd[i]);
         n_vec++;
         if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {2'b11, ea[i], ed[i], em[i]}) begin
            n_err++;
            $display("FAIL st%0d_req got v=%b wen=%b addr=%h data=%h mask=%h exp 1 1 %h %h %h",
                     i, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, ea[i], ed[i], em[i]);
         end
         tick();
         respond(32'hFFFF_FFFF);
         n_vec++;
         if ({out_valid, out_err, out_rdata} !== {2'b10, 32'h0}) begin
            n_err++;
            $display("FAIL st%0d_ack got v=%b err=%b rdata=%h exp 1 0 00000000",
                     i, out_valid, out_err, out_rdata);
         end
         finish_resp();
         $display("txn store size=%0d addr=%h wdata=%h mask=%h", sz[i], ad[i], ed[i], em[i]);
      end
   endtask

   task automatic test_backpressure();
      mem_req_ready = 1'b0;
      issue(1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'hA5A5_5A5A);
      for (int c = 0; c < 5; c++) begin
         n_vec++;
         if ({mem_req_valid, mem_addr, mem_wdata} !== {1'b1, 32'h8000_0010, 32'hA5A5_5A5A}) begin
            n_err++;
            $display("FAIL bp_hold%0d got v=%b addr=%h data=%h exp 1 80000010 a5a55a5a",
                     c, mem_req_valid, mem_addr, mem_wdata);
         end
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_early got out_valid=%b exp 0", out_valid);
      end
      respond(32'h0);
      n_vec++;
      if ({out_valid, out_err} !== 2'b10) begin
         n_err++;
         $display("FAIL bp_resp got v=%b err=%b exp 1 0", out_valid, out_err);
      end
      finish_resp();
      $display("txn store with 5 stall cycles addr=80000010");
   endtask

   task automatic test_timeout();
      int waited = 0;
      issue(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0);
      tick();
      while (!out_valid && waited < 20) begin
         tick();
         waited++;
      end
      n_vec++;
      if (waited !== 4) begin
         n_err++;
         $display("FAIL to_cycles got %0d exp 4", waited);
      end
      n_vec++;
      if ({out_valid, out_err, out_rdata} !== {2'b11, 32'h0}) begin
         n_err++;
         $display("FAIL to_resp got v=%b err=%b rdata=%h exp 1 1 00000000", out_valid, out_err, out_rdata);
      end
      finish_resp();
      respond(32'h1111_1111);
      respond(32'h2222_2222);
      n_vec++;
      if ({in_ready, out_valid, mem_req_valid} !== 3'b100) begin
         n_err++;
         $display("FAIL to_late_rsp got rdy/v/req=%b%b%b exp 100", in_ready, out_valid, mem_req_valid);
      end
      issue(1'b0, 2'd2, 1'b0, 32'h8000_0024, 32'h0);
      tick();
      respond(32'h0BAD_F00D);
      n_vec++;
      if ({out_valid, out_err, out_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
         n_err++;
         $display("FAIL to_recover got v=%b err=%b rdata=%h exp 1 0 0badf00d", out_valid, out_err, out_rdata);
      end
      finish_resp();
      $display("txn timeout after %0d wait cycles, recovery load ok", waited);
   endtask

   task automatic test_misalign();
`ifdef YSYX_24080014_LSU_MISALIGN_EN
      in_valid = 1'b1; in_wen = 1'b0; in_size = 2'd2; in_unsigned = 1'b0;
      in_addr = 32'h8000_0001; in_wdata = 32'h0;
      tick();
      in_valid = 1'b0;
      n_vec++;
      if ({mem_req_valid, out_valid, out_err, out_rdata} !== {3'b011, 32'h0}) begin
         n_err++;
         $display("FAIL mis_resp got req=%b v=%b err=%b rdata=%h exp 0 1 1 00000000",
                  mem_req_valid, out_valid, out_err, out_rdata);
      end
      finish_resp();
      $display("txn misaligned word @80000001 rejected");
`else
      issue(1'b1, 2'd1, 1'b0, 32'h8000_0001, 32'h0000_BEEF);
      n_vec++;
      if ({mem_req_valid, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 32'h8000_0000, 32'h0000_BEEF, 4'h3}) begin
         n_err++;
         $display("FAIL mis_align got v=%b addr=%h data=%h mask=%h exp 1 80000000 0000beef 3",
                  mem_req_valid, mem_addr, mem_wdata, mem_wmask);
      end
      tick();
      respond(32'h0);
      finish_resp();
      $display("txn misaligned half store @80000001 aligned down");
`endif
   endtask

   task automatic test_reset_in_wait();
      issue(1'b0, 2'd2, 1'b0, 32'h8000_0030, 32'h0);
      tick();
      rst = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'h5555_5555;
      tick();
      rst = 1'b0;
      n_vec++;
      if ({in_ready, out_valid, mem_req_valid, out_err} !== 4'b1000) begin
         n_err++;
         $display("FAIL rw_after_rst got rdy/v/req/err=%b%b%b%b exp 1000",
                  in_ready, out_valid, mem_req_valid, out_err);
      end
      tick();
      mem_rsp_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rw_stale got out_valid=%b exp 0", out_valid);
      end
      issue(1'b0, 2'd0, 1'b1, 32'h8000_0032, 32'h0);
      tick();
      respond(32'h00C3_0000);
      n_vec++;
      if ({out_valid, out_err, out_rdata} !== {2'b10, 32'h0000_00C3}) begin
         n_err++;
         $display("FAIL rw_next got v=%b err=%b rdata=%h exp 1 0 000000c3", out_valid, out_err, out_rdata);
      end
      finish_resp();
      $display("txn reset during WAIT, next load rdata=000000c3");
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
      in_addr = '0; in_wdata = '0; out_ready = 1'b0; mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
      test_reset();
      test_load_byte();
      test_load_variants();
      test_store();
      test_backpressure();
      test_timeout();
      test_misalign();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
